// File: rtl/wvb_overflow_mgr.sv
// Multi-channel waveform buffer occupancy and overflow manager.
// Each channel tracks the read side's last-read address and derives the words
// in use, a combinational overflow flag, a hysteretic almost-full flag and a
// set of clearable overflow statistics. Channels are fully independent apart
// from the any_overflow reduction.
module wvb_overflow_mgr #(
   parameter int P_N_CHAN      = 1,
   parameter int P_ADR_WIDTH   = 12,
   parameter int P_WUSED_WIDTH = 16,
   parameter int P_CNT_WIDTH   = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [P_N_CHAN*P_ADR_WIDTH-1:0]    wvb_wr_addr,
   input  logic [P_N_CHAN-1:0]                wvb_rddone,
   input  logic [P_N_CHAN*P_ADR_WIDTH-1:0]    rd_stop_addr,
   input  logic [P_N_CHAN-1:0]                hdr_full,
   input  logic [P_WUSED_WIDTH-1:0]           cfg_thresh_hi,
   input  logic [P_WUSED_WIDTH-1:0]           cfg_thresh_lo,
   input  logic [P_N_CHAN-1:0]                stat_clr,
   output logic [P_N_CHAN-1:0]                overflow,
   output logic                               any_overflow,
   output logic [P_N_CHAN-1:0]                almost_full,
   output logic [P_N_CHAN*P_WUSED_WIDTH-1:0]  wvb_wused,
   output logic [P_N_CHAN-1:0]                ovf_sticky,
   output logic [P_N_CHAN*P_CNT_WIDTH-1:0]    ovf_cnt,
   output logic [P_N_CHAN*P_WUSED_WIDTH-1:0]  wused_peak
);

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_HIGH   = 1'b1
   } af_state_t;

   assign any_overflow = |overflow;

   genvar gi;
   generate
      for (gi = 0; gi < P_N_CHAN; gi++) begin : g_chan
         logic [P_ADR_WIDTH-1:0]   wr_addr;
         logic [P_ADR_WIDTH-1:0]   stop_addr;
         logic [P_ADR_WIDTH-1:0]   last_rd_q;
         logic [P_ADR_WIDTH-1:0]   last_rd_d;
         logic [P_ADR_WIDTH-1:0]   next_rd;
         logic [P_ADR_WIDTH-1:0]   wused_adr;
         logic [P_WUSED_WIDTH-1:0] wused;
         logic                     ovf;
         logic                     ovf_prev_q;
         logic                     ovf_rise;
         logic                     sticky_q;
         logic                     sticky_d;
         logic [P_CNT_WIDTH-1:0]   cnt_q;
         logic [P_CNT_WIDTH-1:0]   cnt_d;
         logic [P_WUSED_WIDTH-1:0] peak_q;
         logic [P_WUSED_WIDTH-1:0] peak_d;
         af_state_t                af_state_q;
         af_state_t                af_state_d;

         assign wr_addr   = wvb_wr_addr[gi*P_ADR_WIDTH +: P_ADR_WIDTH];
         assign stop_addr = rd_stop_addr[gi*P_ADR_WIDTH +: P_ADR_WIDTH];

         // Occupancy uses modular subtraction so write-pointer wrap needs no special case.
         assign next_rd   = last_rd_q + 1'b1;
         assign wused_adr = wr_addr - next_rd;
         assign wused     = P_WUSED_WIDTH'(wused_adr);

         // Overflow is immediate: the writer has caught up with the last unread word.
         assign ovf      = hdr_full[gi] | (wr_addr == last_rd_q);
         assign ovf_rise = ovf & ~ovf_prev_q;

         assign overflow[gi]                                   = ovf;
         assign wvb_wused[gi*P_WUSED_WIDTH +: P_WUSED_WIDTH]   = wused;
         assign almost_full[gi]                                = (af_state_q == ST_HIGH);
         assign ovf_sticky[gi]                                 = sticky_q;
         assign ovf_cnt[gi*P_CNT_WIDTH +: P_CNT_WIDTH]         = cnt_q;
         assign wused_peak[gi*P_WUSED_WIDTH +: P_WUSED_WIDTH]  = peak_q;

         // Almost-full hysteresis: each state only evaluates its own exit threshold.
         always_comb begin
            af_state_d = af_state_q;
            case (af_state_q)
               ST_NORMAL: if (wused >= cfg_thresh_hi) af_state_d = ST_HIGH;
               ST_HIGH:   if (wused <= cfg_thresh_lo) af_state_d = ST_NORMAL;
               default:   af_state_d = ST_NORMAL;
            endcase
         end

         // Next-state for read pointer and statistics; a coinciding event beats stat_clr.
         always_comb begin
            last_rd_d = last_rd_q;
            if (wvb_rddone[gi]) last_rd_d = stop_addr;

            sticky_d = ovf | (sticky_q & ~stat_clr[gi]);

            cnt_d = cnt_q;
            if (stat_clr[gi]) begin
               cnt_d = ovf_rise ? P_CNT_WIDTH'(1) : '0;
            end else if (ovf_rise && (cnt_q != {P_CNT_WIDTH{1'b1}})) begin
               cnt_d = cnt_q + 1'b1;
            end

            peak_d = peak_q;
            if (stat_clr[gi] || (wused > peak_q)) peak_d = wused;
         end

         // Almost-full state register.
         always_ff @(posedge clk) begin
            if (rst) af_state_q <= ST_NORMAL;
            else     af_state_q <= af_state_d;
         end

         // Read pointer, overflow history and statistics registers.
         always_ff @(posedge clk) begin
            if (rst) begin
               last_rd_q  <= '1;
               ovf_prev_q <= 1'b0;
               sticky_q   <= 1'b0;
               cnt_q      <= '0;
               peak_q     <= '0;
            end else begin
               last_rd_q  <= last_rd_d;
               ovf_prev_q <= ovf;
               sticky_q   <= sticky_d;
               cnt_q      <= cnt_d;
               peak_q     <= peak_d;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_wvb_overflow_mgr.sv
// Directed bench for wvb_overflow_mgr: two channels, 12-bit addresses,
// 4-bit counters so saturation is reachable quickly.
module tb_wvb_overflow_mgr;

   localparam int NC = 2;
   localparam int AW = 12;
   localparam int WW = 16;
   localparam int CW = 4;

   logic                 clk;
   logic                 rst;
   logic [NC*AW-1:0]     wvb_wr_addr;
   logic [NC-1:0]        wvb_rddone;
   logic [NC*AW-1:0]     rd_stop_addr;
   logic [NC-1:0]        hdr_full;
   logic [WW-1:0]        cfg_thresh_hi;
   logic [WW-1:0]        cfg_thresh_lo;
   logic [NC-1:0]        stat_clr;
   logic [NC-1:0]        overflow;
   logic                 any_overflow;
   logic [NC-1:0]        almost_full;
   logic [NC*WW-1:0]     wvb_wused;
   logic [NC-1:0]        ovf_sticky;
   logic [NC*CW-1:0]     ovf_cnt;
   logic [NC*WW-1:0]     wused_peak;

   int n_tests = 0;
   int n_fail  = 0;

   wvb_overflow_mgr #(
      .P_N_CHAN      (NC),
      .P_ADR_WIDTH   (AW),
      .P_WUSED_WIDTH (WW),
      .P_CNT_WIDTH   (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .wvb_wr_addr   (wvb_wr_addr),
      .wvb_rddone    (wvb_rddone),
      .rd_stop_addr  (rd_stop_addr),
      .hdr_full      (hdr_full),
      .cfg_thresh_hi (cfg_thresh_hi),
      .cfg_thresh_lo (cfg_thresh_lo),
      .stat_clr      (stat_clr),
      .overflow      (overflow),
      .any_overflow  (any_overflow),
      .almost_full   (almost_full),
      .wvb_wused     (wvb_wused),
      .ovf_sticky    (ovf_sticky),
      .ovf_cnt       (ovf_cnt),
      .wused_peak    (wused_peak)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input int ch, input logic [AW-1:0] v);
      wvb_wr_addr[ch*AW +: AW] = v;
      #1;
   endtask

   function automatic logic [31:0] wused_of(input int ch);
      return 32'(wvb_wused[ch*WW +: WW]);
   endfunction

   function automatic logic [31:0] peak_of(input int ch);
      return 32'(wused_peak[ch*WW +: WW]);
   endfunction

   function automatic logic [31:0] cnt_of(input int ch);
      return 32'(ovf_cnt[ch*CW +: CW]);
   endfunction

   initial begin
      rst           = 1'b1;
      wvb_wr_addr   = '0;
      wvb_rddone    = '0;
      rd_stop_addr  = '0;
      hdr_full      = '0;
      cfg_thresh_hi = 16'd3000;
      cfg_thresh_lo = 16'd1000;
      stat_clr      = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;

      // Reset state
      chk("rst_wused0",  wused_of(0), 0);
      chk("rst_ovf",     32'(overflow), 0);
      chk("rst_any",     32'(any_overflow), 0);
      chk("rst_af",      32'(almost_full), 0);
      chk("rst_sticky",  32'(ovf_sticky), 0);
      chk("rst_cnt0",    cnt_of(0), 0);
      chk("rst_peak0",   peak_of(0), 0);

      // Occupancy follows write address with zero latency
      set_wr(0, 12'd100);
      chk("wused_100", wused_of(0), 100);
      tick();
      chk("peak_100", peak_of(0), 100);

      // Almost-full hysteresis
      set_wr(0, 12'd2999);
      tick();
      chk("af_2999", 32'(almost_full[0]), 0);
      set_wr(0, 12'd3000);
      chk("af_3000_same_cyc", 32'(almost_full[0]), 0);
      tick();
      chk("af_3000_next", 32'(almost_full[0]), 1);
      set_wr(0, 12'd2000);
      tick();
      chk("af_2000_hold", 32'(almost_full[0]), 1);
      set_wr(0, 12'd1000);
      tick();
      chk("af_1000_clr", 32'(almost_full[0]), 0);

      // Full buffer with no reads
      set_wr(0, 12'd4095);
      chk("ovf_4095", 32'(overflow[0]), 1);
      chk("any_4095", 32'(any_overflow), 1);
      chk("sticky_before", 32'(ovf_sticky[0]), 0);
      tick();
      chk("sticky_after", 32'(ovf_sticky[0]), 1);
      chk("cnt_first", cnt_of(0), 1);
      for (int i = 0; i < 10; i++) tick();
      chk("cnt_hold10", cnt_of(0), 1);
      chk("peak_4095", peak_of(0), 4095);

      // Read completion with stop address 4000; overflow uses old pointer this cycle
      rd_stop_addr[0 +: AW] = 12'd4000;
      wvb_rddone[0] = 1'b1;
      #1;
      chk("ovf_during_rddone", 32'(overflow[0]), 1);
      tick();
      wvb_rddone[0] = 1'b0;
      #1;
      chk("ovf_after_rddone", 32'(overflow[0]), 0);
      chk("wused_94", wused_of(0), 94);
      set_wr(0, 12'd50);
      chk("wused_wrap_145", wused_of(0), 145);
      chk("ovf_wrap", 32'(overflow[0]), 0);

      // stat_clr on ch0: counter and sticky cleared, peak reloads current wused
      stat_clr[0] = 1'b1;
      tick();
      stat_clr[0] = 1'b0;
      #1;
      chk("clr_cnt0", cnt_of(0), 0);
      chk("clr_sticky0", 32'(ovf_sticky[0]), 0);
      chk("clr_peak0", peak_of(0), 145);

      // Three hdr_full pulses on ch1
      for (int i = 0; i < 3; i++) begin
         hdr_full[1] = 1'b1;
         tick();
         hdr_full[1] = 1'b0;
         tick();
      end
      chk("cnt1_3", cnt_of(1), 3);
      chk("cnt0_untouched", cnt_of(0), 0);
      chk("sticky0_untouched", 32'(ovf_sticky[0]), 0);

      // Fourth rising edge coincides with stat_clr: counter restarts at 1, sticky set
      hdr_full[1] = 1'b1;
      stat_clr[1] = 1'b1;
      #1;
      chk("any_from_ch1", 32'(any_overflow), 1);
      tick();
      stat_clr[1] = 1'b0;
      hdr_full[1] = 1'b0;
      #1;
      chk("cnt1_clr_edge", cnt_of(1), 1);
      chk("sticky1_clr_edge", 32'(ovf_sticky[1]), 1);

      // Saturation: 20 more pulses on a 4-bit counter
      for (int i = 0; i < 20; i++) begin
         hdr_full[1] = 1'b1;
         tick();
         hdr_full[1] = 1'b0;
         tick();
      end
      chk("cnt1_sat", cnt_of(1), 15);

      // Reset mid-operation
      set_wr(0, 12'd3500);
      tick();
      chk("af_3500", 32'(almost_full[0]), 1);
      chk("wused_3500_old_ptr", wused_of(0), 3595);
      rst = 1'b1;
      tick();
      chk("midrst_af", 32'(almost_full), 0);
      chk("midrst_sticky", 32'(ovf_sticky), 0);
      chk("midrst_cnt1", cnt_of(1), 0);
      chk("midrst_peak0", peak_of(0), 0);
      chk("midrst_wused0", wused_of(0), 3500);
      rst = 1'b0;
      set_wr(0, 12'd0);
      tick();
      chk("post_rst_wused0", wused_of(0), 0);
      chk("post_rst_peak0", peak_of(0), 0);
      chk("post_rst_any", 32'(any_overflow), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wvb_overflow_mgr.md
Name: wvb_overflow_mgr

Overview:
- Multi-channel waveform buffer occupancy and overflow manager: the parametrised successor to the single-channel overflow controller.
- Per channel, it tracks the last-read address from the read side and flags overflow.
- Beyond the single-channel block, it adds:
  - a hysteretic almost-full flag
  - a sticky overflow flag
  - a saturating overflow-event counter
  - a peak-occupancy tracker
- Sits between the per-channel wvb writers/header FIFOs and the readout arbiter. Header fan-out is done upstream, so stop addresses arrive pre-extracted.

Parameters:
- P_N_CHAN, 1, number of waveform buffer channels
- P_ADR_WIDTH, 12, buffer address width; depth = 2^P_ADR_WIDTH; must be <= P_WUSED_WIDTH
- P_WUSED_WIDTH, 16, width of occupancy outputs and thresholds
- P_CNT_WIDTH, 16, width of per-channel overflow-event counters

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wvb_wr_addr  in  P_N_CHAN*P_ADR_WIDTH  per-channel current write address; channel i in bits [i*P_ADR_WIDTH +: P_ADR_WIDTH]
- wvb_rddone  in  P_N_CHAN  per-channel one-cycle pulse: event fully read
- rd_stop_addr  in  P_N_CHAN*P_ADR_WIDTH  stop address (last written address) of the event being completed; valid when wvb_rddone[i]
- hdr_full  in  P_N_CHAN  per-channel header FIFO full
- cfg_thresh_hi  in  P_WUSED_WIDTH  almost-full assert threshold, shared by all channels
- cfg_thresh_lo  in  P_WUSED_WIDTH  almost-full deassert threshold, shared by all channels
- stat_clr  in  P_N_CHAN  per-channel one-cycle pulse: clear sticky flag, counter and peak
- overflow  out  P_N_CHAN  per-channel overflow, combinational
- any_overflow  out  1  OR of overflow
- almost_full  out  P_N_CHAN  hysteretic occupancy flag, registered
- wvb_wused  out  P_N_CHAN*P_WUSED_WIDTH  per-channel words used, combinational
- ovf_sticky  out  P_N_CHAN  latched overflow, registered
- ovf_cnt  out  P_N_CHAN*P_CNT_WIDTH  overflow rising-edge count, registered
- wused_peak  out  P_N_CHAN*P_WUSED_WIDTH  maximum wvb_wused since reset or clear, registered

Behaviour:
- The same logic is replicated per channel i. There is no cross-channel interaction except any_overflow.
- last_rd_addr[i]:
  - P_ADR_WIDTH register; reset value all ones.
  - On wvb_rddone[i], it loads rd_stop_addr[i] on the next edge.
  - rst has priority over wvb_rddone.
- next_rd[i] = last_rd_addr[i] + 1, computed mod 2^P_ADR_WIDTH.
- wvb_wused[i] = (wvb_wr_addr[i] - next_rd[i]) mod 2^P_ADR_WIDTH, zero-extended to P_WUSED_WIDTH.
  - Wrap-around is handled by modular subtraction.
  - After reset with wr_addr = 0, wused = 0.
- overflow[i] = hdr_full[i] OR (wvb_wr_addr[i] == last_rd_addr[i]). It is combinational with zero latency, so overflow asserts when wused = 2^P_ADR_WIDTH - 1.
- almost_full FSM, 2 states per channel:
  - NORMAL (reset) -> HIGH when wvb_wused >= cfg_thresh_hi.
  - HIGH -> NORMAL when wvb_wused <= cfg_thresh_lo.
  - Otherwise it holds state. almost_full = (state == HIGH), with 1-cycle latency from wused.
  - If cfg_thresh_lo >= cfg_thresh_hi, the evaluation order is: in NORMAL only the hi test applies; in HIGH only the lo test applies. The result is no oscillation within one cycle.
- ovf_prev[i]: registered copy of overflow[i]; reset value 0. A rising edge is overflow & ~ovf_prev.
- ovf_sticky:
  - Set on any cycle with overflow = 1; cleared by stat_clr.
  - If set and clear coincide, set wins (sticky = 1).
  - Reset value 0.
- ovf_cnt:
  - Increments by 1 on each rising edge; saturates at all ones (no wrap).
  - stat_clr forces 0; if a rising edge coincides with stat_clr, the result is 1.
  - Reset value 0.
- wused_peak:
  - Loads wvb_wused when wvb_wused > wused_peak.
  - stat_clr loads the current wvb_wused rather than 0.
  - Reset value 0.
- Reset mid-operation: every register returns to its reset value on the next edge. wused then reflects wr_addr - 0; the writer is reset concurrently.
- Outputs after reset with wr_addr = 0 and hdr_full = 0:
  - overflow = 0, any_overflow = 0, almost_full = 0, wvb_wused = 0
  - ovf_sticky = 0, ovf_cnt = 0, wused_peak = 0
- Simultaneous wvb_rddone and overflow: overflow is evaluated against the old last_rd_addr in that cycle and the new value from the next cycle.

Test Plan:
- Reset, P_ADR_WIDTH=12, wr_addr=0 -> wused=0, overflow=0, all stats 0. Step wr_addr to 100 -> wused=100 in the same cycle.
- wr_addr=4095 with no reads -> overflow=1, any_overflow=1, ovf_sticky=1 next cycle, ovf_cnt=1. Hold 10 cycles -> ovf_cnt stays 1.
- rddone with stop_addr=4000, then wr_addr wraps to 50 -> wused = (50 - 4001) mod 4096 = 145. overflow=0.
- thresh_hi=3000, thresh_lo=1000; ramp wused 0->3000 -> almost_full=1 one cycle after 3000. Drop to 2000 -> still 1. Drop to 1000 -> 0 next cycle.
- Toggle hdr_full[1] 3 times with 2 channels -> ovf_cnt ch1 = 3, ch0 = 0. Pulse stat_clr[1] together with a 4th rising edge -> ovf_cnt=1, sticky=1.
- P_CNT_WIDTH=4; 20 overflow pulses -> ovf_cnt=15 (saturated). Assert rst mid-ramp -> all registers return to reset values next edge.
